// File: rtl/imm_gen_seq_if.sv
// rtl/imm_gen_seq_if.sv - request/result handshake bundle for the immediate generator
interface imm_gen_seq_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [23:0]       immediate;
  logic [1:0]        imm_src;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] data;
  logic              carry_out;
  logic              busy;

  modport master (
    output in_valid, immediate, imm_src, out_ready,
    input  in_ready, out_valid, data, carry_out, busy
  );

  modport slave (
    input  in_valid, immediate, imm_src, out_ready,
    output in_ready, out_valid, data, carry_out, busy
  );
endinterface

// File: rtl/imm_gen_seq.sv
// rtl/imm_gen_seq.sv - sequential immediate generator with serial STEP-bit rotator
// IMM_GEN_FASTROT_EN: replace the serial rotator with a single-cycle one (no ROT state)
module imm_gen_seq #(
  parameter int DATA_W = 32,
  parameter int STEP   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  imm_gen_seq_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_ROT, S_HOLD} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              carry_q, carry_d;
  logic [DATA_W-1:0] ext;
  logic [4:0]        rot_amt;

  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input logic [4:0] n);
    logic [2*DATA_W-1:0] dbl;
    dbl = {x, x} >> n;
    return dbl[DATA_W-1:0];
  endfunction

  always_comb begin
    ext = '1;
    case (bus.imm_src)
      2'd0: ext = {{(DATA_W-8){1'b0}}, bus.immediate[7:0]};
      2'd1: ext = {{(DATA_W-12){1'b0}}, bus.immediate[11:0]};
      2'd2: ext = {{(DATA_W-26){bus.immediate[23]}}, bus.immediate, 2'b00};
      default: ext = '1;
    endcase
  end

  // Only data-processing immediates rotate; other modes see a zero distance.
  assign rot_amt = (bus.imm_src == 2'd0) ? {bus.immediate[11:8], 1'b0} : 5'd0;

`ifndef IMM_GEN_FASTROT_EN
  logic [4:0]        rem_q, rem_d;
  logic [4:0]        step_amt;
  logic [DATA_W-1:0] rot_next;

  assign step_amt = (rem_q < 5'(STEP)) ? rem_q : 5'(STEP);
  assign rot_next = rotr(data_q, step_amt);
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    carry_d = carry_q;
`ifndef IMM_GEN_FASTROT_EN
    rem_d   = rem_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
`ifdef IMM_GEN_FASTROT_EN
          data_d  = rotr(ext, rot_amt);
          carry_d = (rot_amt != 5'd0) && data_d[DATA_W-1];
          state_d = S_HOLD;
`else
          data_d  = ext;
          carry_d = 1'b0;
          rem_d   = rot_amt;
          state_d = (rot_amt != 5'd0) ? S_ROT : S_HOLD;
`endif
        end
      end
`ifndef IMM_GEN_FASTROT_EN
      S_ROT: begin
        // Last partial step lands in HOLD with the carry taken from the final MSB.
        data_d = rot_next;
        rem_d  = rem_q - step_amt;
        if (rem_d == 5'd0) begin
          carry_d = rot_next[DATA_W-1];
          state_d = S_HOLD;
        end
      end
`endif
      S_HOLD: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      carry_q <= 1'b0;
`ifndef IMM_GEN_FASTROT_EN
      rem_q   <= 5'd0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      carry_q <= carry_d;
`ifndef IMM_GEN_FASTROT_EN
      rem_q   <= rem_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_HOLD);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.data      = data_q;
  assign bus.carry_out = carry_q;
endmodule

// File: tb/tb_imm_gen_seq.sv
// tb/tb_imm_gen_seq.sv - scoreboard bench for imm_gen_seq with directed vectors
module tb_imm_gen_seq;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   seen = 1'b0;

  typedef struct {
    logic [31:0] d;
    logic        c;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sb[$];

`ifdef IMM_GEN_FASTROT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  imm_gen_seq_if #(.DATA_W(32)) bus ();

  imm_gen_seq #(.DATA_W(32), .STEP(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  // Monitor: compares the first cycle of every presented result against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n || !bus.out_valid) begin
      seen = 1'b0;
    end else if (!seen) begin
      seen = 1'b1;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%0h expected=none", bus.data);
      end else begin
        e = sb.pop_front();
        chk("data", 64'(bus.data), 64'(e.d));
        chk("carry_out", 64'(bus.carry_out), 64'(e.c));
        chk("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
      end
    end
  end

  task automatic issue(input logic [1:0] src, input logic [23:0] imm, input logic [31:0] d,
                       input logic c, input int lat, input bit track);
    exp_t e;
    bit   got;
    got = 1'b0;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.imm_src   = src;
    bus.immediate = imm;
    for (int i = 0; i < 50; i++) begin
      if (bus.in_ready) begin
        got = 1'b1;
        if (track) begin
          e.d = d; e.c = c; e.lat = lat; e.acc = cyc + 1;
          sb.push_back(e);
        end
        break;
      end
      @(negedge clk);
    end
    if (!got) fail_now("accept_timeout");
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!bus.busy && sb.size() == 0) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!done) fail_now("idle_timeout");
  endtask

  initial begin
    exp_t e;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.imm_src   = 2'd0;
    bus.immediate = 24'd0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_data", 64'(bus.data), 64'd0);
    chk("rst_carry", 64'(bus.carry_out), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    rst_n = 1'b1;

    issue(2'd0, 24'h0004FF, 32'hFF000000, 1'b1, FAST ? 1 : 5, 1'b1);  wait_idle();
    issue(2'd1, 24'hFFFABC, 32'h00000ABC, 1'b0, 1, 1'b1);              wait_idle();
    issue(2'd0, 24'h000F01, 32'h00000004, 1'b0, FAST ? 1 : 16, 1'b1); wait_idle();
    issue(2'd0, 24'h0000A5, 32'h000000A5, 1'b0, 1, 1'b1);              wait_idle();
    issue(2'd0, 24'h000181, 32'h40000020, 1'b0, FAST ? 1 : 2, 1'b1);  wait_idle();
    issue(2'd0, 24'h00028F, 32'hF0000008, 1'b1, FAST ? 1 : 3, 1'b1);  wait_idle();
    issue(2'd2, 24'h800001, 32'hFE000004, 1'b0, 1, 1'b1);              wait_idle();
    issue(2'd2, 24'h000010, 32'h00000040, 1'b0, 1, 1'b1);              wait_idle();
    issue(2'd3, 24'h123456, 32'hFFFFFFFF, 1'b0, 1, 1'b1);              wait_idle();

    // Backpressure with a competing request held on the input side.
    bus.out_ready = 1'b0;
    issue(2'd1, 24'h000123, 32'h00000123, 1'b0, 1, 1'b1);
    bus.in_valid  = 1'b1;
    bus.imm_src   = 2'd3;
    bus.immediate = 24'h000000;
    for (int i = 0; i < 3; i++) begin
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_data", 64'(bus.data), 64'h123);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
    chk("bp_release_out_valid", 64'(bus.out_valid), 64'd0);
    e.d = 32'hFFFFFFFF; e.c = 1'b0; e.lat = 1; e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_idle();

    // Reset in the middle of a rotation: nothing may be presented for it.
    issue(2'd0, 24'h0004FF, 32'h0, 1'b0, 0, 1'b0);
    chk("rot_busy", 64'(bus.busy), FAST ? 64'd1 : 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_data", 64'(bus.data), 64'd0);
    chk("abort_carry", 64'(bus.carry_out), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (25) @(negedge clk);
    chk("abort_quiet_busy", 64'(bus.busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
